// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_slave_regfile
//  Purpose  : I2C slave with a byte-wide register file.
//             - Oversamples SCL/SDA on clk and detects START, repeated START and STOP.
//             - Matches a 7-bit device address.
//             - Multi-byte writes and reads use an auto-incrementing register pointer.
//             - SDA is driven open-drain for ACK and read data.
//             - A local port gives the fabric access to the same registers.
//  Ports    : clk, reset           system clock, synchronous active-high reset
//             scl_in, sda_in       asynchronous I2C pad inputs
//             sda_oe               1 = pull SDA low
//             loc_wr_en/loc_addr/loc_wr_data/loc_rd_data   local register port
//             busy                 addressed transaction in progress
//             wr_strobe/wr_index   one-cycle notification of an I2C register write
//  Revision : 1.0  initial release
// ============================================================================
module i2c_slave_regfile #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h42,
    parameter int         REG_AW      = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scl_in,
    input  logic              sda_in,
    output logic              sda_oe,
    input  logic              loc_wr_en,
    input  logic [REG_AW-1:0] loc_addr,
    input  logic [7:0]        loc_wr_data,
    output logic [7:0]        loc_rd_data,
    output logic              busy,
    output logic              wr_strobe,
    output logic [REG_AW-1:0] wr_index
);

    localparam int c_NUM_REGS = 2 ** REG_AW;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_ADDR     = 4'd1,
        S_ADDR_ACK = 4'd2,
        S_PTR      = 4'd3,
        S_PTR_ACK  = 4'd4,
        S_WR_DATA  = 4'd5,
        S_WR_ACK   = 4'd6,
        S_RD_DATA  = 4'd7,
        S_RD_ACK   = 4'd8,
        S_IGNORE   = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Pad synchronisers plus one history flop for edge detection.
    // They reset to the idle-bus level (high) so that leaving reset
    // never fabricates a START or STOP.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
            r_scl_d    <= r_scl_sync[SYNC_STAGES-1];
            r_sda_d    <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl_s, w_sda_s, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl_s    = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s    = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl_s & ~r_scl_d;
    assign w_scl_fall = ~w_scl_s & r_scl_d;
    // SDA may only move while SCL is high for a bus condition.
    assign w_start    = w_scl_s & r_scl_d & r_sda_d & ~w_sda_s;
    assign w_stop     = w_scl_s & r_scl_d & ~r_sda_d & w_sda_s;

    // ------------------------------------------------------------------
    // Protocol state
    // ------------------------------------------------------------------
    state_t            r_state, w_state_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic              r_sda_oe, w_sda_oe_nxt;
    logic              r_busy, w_busy_nxt;
    logic [REG_AW-1:0] r_ptr, w_ptr_nxt;
    logic              r_rw, w_rw_nxt;
    logic              r_ack, w_ack_nxt;
    logic              w_commit;
    logic              r_wr_strobe;
    logic [REG_AW-1:0] r_wr_index;
    logic [7:0]        r_regs [c_NUM_REGS];
    logic [7:0]        w_rd_byte;

    assign w_rd_byte = r_regs[r_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= '0;
            r_rw        <= 1'b0;
            r_ack       <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_index  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_busy      <= w_busy_nxt;
            r_ptr       <= w_ptr_nxt;
            r_rw        <= w_rw_nxt;
            r_ack       <= w_ack_nxt;
            r_wr_strobe <= w_commit;
            if (w_commit) begin
                r_wr_index <= r_ptr;
            end
        end
    end

    // All SDA drive changes are taken on an SCL falling edge so the
    // line only moves while SCL is low.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_sda_oe_nxt = r_sda_oe;
        w_busy_nxt   = r_busy;
        w_ptr_nxt    = r_ptr;
        w_rw_nxt     = r_rw;
        w_ack_nxt    = r_ack;
        w_commit     = 1'b0;

        if (w_stop) begin
            w_state_nxt  = S_IDLE;
            w_sda_oe_nxt = 1'b0;
            w_busy_nxt   = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WR_DATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt = {r_shift[6:0], w_sda_s};
                        w_cnt_nxt   = r_cnt + 4'd1;
                    end else if (w_scl_fall && r_cnt == 4'd8) begin
                        w_cnt_nxt = '0;
                        if (r_state == S_ADDR) begin
                            if (r_shift[7:1] == SLAVE_ADDR) begin
                                w_state_nxt  = S_ADDR_ACK;
                                w_sda_oe_nxt = 1'b1;
                                w_busy_nxt   = 1'b1;
                                w_rw_nxt     = r_shift[0];
                            end else begin
                                w_state_nxt = S_IGNORE;
                                w_busy_nxt  = 1'b0;
                            end
                        end else if (r_state == S_PTR) begin
                            w_ptr_nxt    = r_shift[REG_AW-1:0];
                            w_state_nxt  = S_PTR_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end else begin
                            w_commit     = 1'b1;
                            w_ptr_nxt    = r_ptr + 1'b1;
                            w_state_nxt  = S_WR_ACK;
                            w_sda_oe_nxt = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (r_rw) begin
                            // Byte is captured here, so later local writes
                            // cannot disturb the byte being shifted out.
                            w_state_nxt  = S_RD_DATA;
                            w_shift_nxt  = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt  = S_PTR;
                            w_sda_oe_nxt = 1'b0;
                        end
                    end
                end
                S_PTR_ACK, S_WR_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt  = S_WR_DATA;
                        w_sda_oe_nxt = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (w_scl_rise) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == 4'd8) begin
                            w_state_nxt  = S_RD_ACK;
                            w_sda_oe_nxt = 1'b0;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_shift_nxt  = {r_shift[6:0], 1'b0};
                            w_sda_oe_nxt = ~r_shift[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (w_scl_rise) begin
                        w_ack_nxt = ~w_sda_s;
                        w_ptr_nxt = r_ptr + 1'b1;
                    end else if (w_scl_fall) begin
                        if (r_ack) begin
                            w_state_nxt  = S_RD_DATA;
                            w_shift_nxt  = w_rd_byte;
                            w_sda_oe_nxt = ~w_rd_byte[7];
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE only leave on START/STOP.
                    w_sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file: an I2C commit is applied after the local write so it
    // takes precedence when both target the same register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (loc_wr_en) begin
                r_regs[loc_addr] <= loc_wr_data;
            end
            if (w_commit) begin
                r_regs[r_ptr] <= r_shift;
            end
        end
    end

    assign loc_rd_data = r_regs[loc_addr];
    // Reset releases SDA combinationally so no low glitch survives it.
    assign sda_oe      = r_sda_oe & ~reset;
    assign busy        = r_busy;
    assign wr_strobe   = r_wr_strobe;
    assign wr_index    = r_wr_index;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_slave_regfile
//  Purpose  : Self-checking bench: bit-banged I2C master plus a byte-level
//             register-file model for i2c_slave_regfile.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int c_NREGS = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       loc_wr_en = 1'b0;
    logic [3:0] loc_addr = 4'd0;
    logic [7:0] loc_wr_data = 8'd0;
    logic       sda_oe, busy, wr_strobe;
    logic [7:0] loc_rd_data;
    logic [3:0] wr_index;
    logic       sda_line;

    assign sda_line = sda_m & ~sda_oe;

    i2c_slave_regfile #(.SLAVE_ADDR(7'h42), .REG_AW(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_m),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .loc_wr_en  (loc_wr_en),
        .loc_addr   (loc_addr),
        .loc_wr_data(loc_wr_data),
        .loc_rd_data(loc_rd_data),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .wr_index   (wr_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int oe_cycles = 0;
    logic [7:0] model_regs [c_NREGS];
    int model_ptr = 0;
    logic [3:0] got_strobe [$];
    logic [3:0] exp_strobe [$];

    always @(negedge clk) begin
        if (wr_strobe) got_strobe.push_back(wr_index);
        if (sda_oe) oe_cycles++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wclk(4);
        scl_m = 1'b1; wclk(6);
        sda_m = 1'b0; wclk(6);
        scl_m = 1'b0; wclk(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wclk(4);
        scl_m = 1'b1; wclk(6);
        sda_m = 1'b1; wclk(6);
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wclk(4);
        scl_m = 1'b1; wclk(8);
        scl_m = 1'b0; wclk(4);
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wclk(4);
        scl_m = 1'b1; wclk(4);
        b = sda_line; wclk(4);
        scl_m = 1'b0; wclk(4);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack_n);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        write_bit(nack);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        loc_addr = a; loc_wr_data = d; loc_wr_en = 1'b1;
        @(negedge clk);
        loc_wr_en = 1'b0;
        model_regs[a] = d;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < c_NREGS; i++) begin
            loc_addr = 4'(i);
            #1;
            check($sformatf("%s_reg%0d", tag, i), loc_rd_data, model_regs[i]);
        end
    endtask

    task automatic check_strobes(input string tag);
        check({tag, "_strobe_count"}, got_strobe.size(), exp_strobe.size());
        for (int i = 0; i < exp_strobe.size() && i < got_strobe.size(); i++)
            check({tag, "_strobe_index"}, got_strobe[i], exp_strobe[i]);
        got_strobe.delete();
        exp_strobe.delete();
    endtask

    // Addressed write: pointer byte then n data bytes (first byte in [7:0]).
    task automatic xfer_write(input string tag, input logic [7:0] p, input int n, input logic [23:0] data);
        logic a;
        i2c_start();
        write_byte(8'h84, a);      check({tag, "_addr_ack"}, a, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        write_byte(p, a);          check({tag, "_ptr_ack"}, a, 1'b0);
        model_ptr = p % c_NREGS;
        for (int k = 0; k < n; k++) begin
            write_byte(data[8*k +: 8], a);
            check({tag, "_data_ack"}, a, 1'b0);
            model_regs[model_ptr] = data[8*k +: 8];
            exp_strobe.push_back(4'(model_ptr));
            model_ptr = (model_ptr + 1) % c_NREGS;
        end
        i2c_stop();
        check({tag, "_busy_after_stop"}, busy, 1'b0);
        check_strobes(tag);
    endtask

    // Read of n bytes, optionally preceded by a pointer write and repeated START.
    task automatic xfer_read(input string tag, input logic set_ptr, input logic [7:0] p, input int n);
        logic a;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            write_byte(8'h84, a);  check({tag, "_waddr_ack"}, a, 1'b0);
            write_byte(p, a);      check({tag, "_ptr_ack"}, a, 1'b0);
            model_ptr = p % c_NREGS;
            i2c_start();
        end
        write_byte(8'h85, a);      check({tag, "_raddr_ack"}, a, 1'b0);
        check({tag, "_busy"}, busy, 1'b1);
        for (int k = 0; k < n; k++) begin
            read_byte(d, (k == n - 1));
            check({tag, "_rdata"}, d, model_regs[model_ptr]);
            model_ptr = (model_ptr + 1) % c_NREGS;
        end
        i2c_stop();
        check({tag, "_busy_after_stop"}, busy, 1'b0);
    endtask

    initial begin : main
        logic a;
        logic b;
        int   oe_before;
        for (int i = 0; i < c_NREGS; i++) model_regs[i] = 8'h00;
        wclk(5);
        reset = 1'b0;
        wclk(2);

        // Reset state
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_index", wr_index, 4'd0);
        check_regs("rst");

        // 1: write two bytes at pointer 3
        xfer_write("t1", 8'h03, 2, 24'h005AA5);
        check_regs("t1");

        // 2: pointer write, repeated START, read two bytes
        xfer_read("t2", 1'b1, 8'h03, 2);
        xfer_read("t2ptr", 1'b0, 8'h00, 1);   // continues from pointer 5

        // 3: address mismatch is ignored entirely
        oe_before = oe_cycles;
        i2c_start();
        write_byte(8'h86, a); check("t3_addr_nack", a, 1'b1);
        check("t3_busy", busy, 1'b0);
        write_byte(8'h01, a); check("t3_data_nack", a, 1'b1);
        write_byte(8'hEE, a); check("t3_data_nack2", a, 1'b1);
        i2c_stop();
        check("t3_no_drive", oe_cycles, oe_before);
        check_strobes("t3");
        check_regs("t3");

        // 4: pointer wrap 15 -> 0
        xfer_write("t4", 8'h0F, 2, 24'h002211);
        check_regs("t4");

        // 5: local write collides with I2C commit on reg 2
        i2c_start();
        write_byte(8'h84, a); check("t5_addr_ack", a, 1'b0);
        write_byte(8'h02, a); check("t5_ptr_ack", a, 1'b0);
        @(negedge clk);
        loc_addr = 4'd2; loc_wr_data = 8'h77; loc_wr_en = 1'b1;
        fork
            write_byte(8'h99, a);
            begin
                for (int k = 0; k < 400 && !wr_strobe; k++) @(negedge clk);
                loc_wr_en = 1'b0;
            end
        join
        check("t5_data_ack", a, 1'b0);
        i2c_stop();
        model_regs[2] = 8'h99;
        exp_strobe.push_back(4'd2);
        check_strobes("t5");
        check_regs("t5");

        // 6: reset during the 5th bit of a read
        loc_write(4'd8, 8'h00);
        i2c_start();
        write_byte(8'h84, a); check("t6_waddr_ack", a, 1'b0);
        write_byte(8'h08, a); check("t6_ptr_ack", a, 1'b0);
        i2c_start();
        write_byte(8'h85, a); check("t6_raddr_ack", a, 1'b0);
        for (int i = 0; i < 4; i++) read_bit(b);
        wclk(3);
        check("t6_driving_bit4", sda_oe, 1'b1);
        reset = 1'b1;
        #1;
        check("t6_release_now", sda_oe, 1'b0);
        @(posedge clk); #1;
        check("t6_release_next", sda_oe, 1'b0);
        check("t6_busy_reset", busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < c_NREGS; i++) model_regs[i] = 8'h00;
        model_ptr = 0;
        wclk(4);
        xfer_write("t6post", 8'h05, 1, 24'h0000C3);
        check_regs("t6");

        // Randomized mix against the model
        for (int it = 0; it < 10; it++) begin
            int op;
            op = $urandom_range(0, 2);
            if (op == 0) begin
                loc_write(4'($urandom_range(0, 15)), 8'($urandom));
            end else if (op == 1) begin
                xfer_write("rnd_w", 8'($urandom), $urandom_range(1, 3), 24'($urandom));
            end else begin
                xfer_read("rnd_r", 1'($urandom), 8'($urandom), $urandom_range(1, 3));
            end
        end
        check_regs("rnd");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
